// File: rtl/race_score_display_if.sv
// Signal bundle between the game top level (master) and the race score display (slave).
// bcdValid is a one-cycle strobe with no back-pressure: it is high in the cycle the new hex digits first appear.
interface race_score_display_if;
    logic [7:0] secondsPassed;
    logic       raceFinished;
    logic       showBest;
    logic       clearBest;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [7:0] bestTime;
    logic       newRecord;
    logic       bcdValid;
    logic [1:0] fsm_state;

    modport master (
        output secondsPassed, raceFinished, showBest, clearBest,
        input  hex0, hex1, hex2, bestTime, newRecord, bcdValid, fsm_state
    );

    modport slave (
        input  secondsPassed, raceFinished, showBest, clearBest,
        output hex0, hex1, hex2, bestTime, newRecord, bcdValid, fsm_state
    );
endinterface

// File: rtl/race_score_display.sv
// Race time / best time display: sequential shift-add-3 binary-to-BCD conversion driving
// three active-low 7-segment digits, plus a best-time record updated on each race finish.
module race_score_display (
    input logic Clock,
    input logic Reset,
    race_score_display_if.slave bus
);
    localparam int WIDTH  = 8;
    localparam int NSHIFT = WIDTH;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2} state_t;

    state_t             state, state_next;
    logic [WIDTH+11:0]  shreg, shreg_adj;
    logic [3:0]         cnt;
    logic               cap_sel, last_sel;
    logic [WIDTH-1:0]   cap_val, last_val, src;
    logic               load, shift_en, latch_en;
    logic [6:0]         hex0_q, hex1_q, hex2_q;
    logic [6:0]         hex0_d, hex1_d, hex2_d;
    logic [3:0]         dig_h, dig_t, dig_u;
    logic               dash;
    logic [WIDTH-1:0]   best_q;
    logic               new_record_q, fin_q, valid_q;
    logic               fin_rise, fin_fall;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    always_comb src = bus.showBest ? best_q : bus.secondsPassed;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        latch_en   = 1'b0;
        case (state)
            IDLE: begin
                if ({bus.showBest, src} != {last_sel, last_val}) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == 4'(NSHIFT - 1)) state_next = LATCH;
            end
            LATCH: begin
                latch_en   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Only the three BCD nibbles are corrected; the binary part shifts through untouched.
    always_comb begin
        shreg_adj = {add3(shreg[WIDTH+11:WIDTH+8]), add3(shreg[WIDTH+7:WIDTH+4]),
                     add3(shreg[WIDTH+3:WIDTH]), shreg[WIDTH-1:0]};
        dig_h  = shreg[WIDTH+11:WIDTH+8];
        dig_t  = shreg[WIDTH+7:WIDTH+4];
        dig_u  = shreg[WIDTH+3:WIDTH];
        dash   = cap_sel && (cap_val == {WIDTH{1'b1}});
        hex2_d = dash ? SEG_DASH : ((dig_h == 4'd0) ? SEG_BLANK : seg(dig_h));
        hex1_d = dash ? SEG_DASH : ((dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg(dig_t));
        hex0_d = dash ? SEG_DASH : seg(dig_u);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            shreg    <= '0;
            cnt      <= '0;
            cap_sel  <= 1'b0;
            cap_val  <= '0;
            last_sel <= 1'b0;
            last_val <= '0;
            hex0_q   <= 7'b1000000;
            hex1_q   <= SEG_BLANK;
            hex2_q   <= SEG_BLANK;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (load) begin
                shreg   <= {12'b0, src};
                cnt     <= '0;
                cap_sel <= bus.showBest;
                cap_val <= src;
            end
            if (shift_en) begin
                shreg <= {shreg_adj[WIDTH+10:0], 1'b0};
                cnt   <= cnt + 4'd1;
            end
            if (latch_en) begin
                hex0_q   <= hex0_d;
                hex1_q   <= hex1_d;
                hex2_q   <= hex2_d;
                last_sel <= cap_sel;
                last_val <= cap_val;
                valid_q  <= 1'b1;
            end
        end
    end

    assign fin_rise = bus.raceFinished && !fin_q;
    assign fin_fall = !bus.raceFinished && fin_q;

    // clearBest outranks a finish in the same cycle; a tie with the record is not a new record.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fin_q        <= 1'b0;
            best_q       <= '1;
            new_record_q <= 1'b0;
        end else begin
            fin_q <= bus.raceFinished;
            if (bus.clearBest) begin
                best_q       <= '1;
                new_record_q <= 1'b0;
            end else if (fin_rise && (bus.secondsPassed < best_q)) begin
                best_q       <= bus.secondsPassed;
                new_record_q <= 1'b1;
            end else if (fin_fall) begin
                new_record_q <= 1'b0;
            end
        end
    end

    assign bus.hex0      = hex0_q;
    assign bus.hex1      = hex1_q;
    assign bus.hex2      = hex2_q;
    assign bus.bestTime  = best_q;
    assign bus.newRecord = new_record_q;
    assign bus.bcdValid  = valid_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_race_score_display.sv
// Directed plus randomized bench for race_score_display: digits are predicted from the value with
// decimal arithmetic, and the best-time record from the min-of-finishes rule.
module tb_race_score_display;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    race_score_display_if bus ();

    race_score_display dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int errors = 0;
    int checks = 0;
    int m_best = 255;
    bit m_nr   = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_hex(input string tag, input bit sel, input int v);
        logic [6:0] e2, e1, e0;
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (sel && v == 255) begin
            e2 = DASH; e1 = DASH; e0 = DASH;
        end else begin
            e2 = (h == 0) ? BLANK : seg_tab[h];
            e1 = (h == 0 && t == 0) ? BLANK : seg_tab[t];
            e0 = seg_tab[u];
        end
        check({tag, ".hex2"}, bus.hex2, e2);
        check({tag, ".hex1"}, bus.hex1, e1);
        check({tag, ".hex0"}, bus.hex0, e0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.bcdValid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".valid_seen"}, bus.bcdValid, 1);
    endtask

    task automatic convert_and_check(input string tag, input bit sel, input int v);
        wait_valid(tag);
        check_hex(tag, sel, v);
        tick();
        check({tag, ".single_pulse"}, bus.bcdValid, 0);
    endtask

    task automatic settle();
        repeat (25) tick();
    endtask

    task automatic race(input string tag, input int t);
        bus.secondsPassed = 8'(t);
        bus.raceFinished  = 1'b1;
        tick();
        if (t < m_best) begin
            m_best = t;
            m_nr   = 1'b1;
        end
        check({tag, ".best"}, bus.bestTime, m_best);
        check({tag, ".new_record"}, bus.newRecord, m_nr);
        bus.raceFinished = 1'b0;
        tick();
        m_nr = 1'b0;
        check({tag, ".record_cleared"}, bus.newRecord, m_nr);
    endtask

    task automatic count_quiet(input string tag, input int cycles);
        int p = 0;
        repeat (cycles) begin
            tick();
            if (bus.bcdValid === 1'b1) p++;
        end
        check({tag, ".no_valid"}, p, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals [3] = '{5, 100, 255};
        bit prev_sel, sel;
        int prev_src, src, v;

        rst = 1'b1;
        bus.secondsPassed = 8'd0;
        bus.raceFinished  = 1'b0;
        bus.showBest      = 1'b0;
        bus.clearBest     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_hex("reset", 1'b0, 0);
        check("reset.best", bus.bestTime, 8'hFF);
        check("reset.new_record", bus.newRecord, 0);
        check("reset.valid", bus.bcdValid, 0);
        count_quiet("reset_idle", 12);

        // Latency: sampled at edge k, digits and strobe appear at edge k+9.
        bus.secondsPassed = 8'd157;
        repeat (9) tick();
        check("lat157.valid_early", bus.bcdValid, 0);
        check("lat157.hex0_old", bus.hex0, 7'b1000000);
        tick();
        check("lat157.valid", bus.bcdValid, 1);
        check("lat157.hex2", bus.hex2, 7'b1111001);
        check("lat157.hex1", bus.hex1, 7'b0010010);
        check("lat157.hex0", bus.hex0, 7'b1111000);
        tick();
        check("lat157.single_pulse", bus.bcdValid, 0);

        foreach (vals[i]) begin
            settle();
            bus.secondsPassed = 8'(vals[i]);
            convert_and_check($sformatf("val%0d", vals[i]), 1'b0, vals[i]);
        end

        settle();
        bus.showBest = 1'b1;
        convert_and_check("dash_no_record", 1'b1, 255);
        bus.showBest = 1'b0;
        settle();

        race("race42a", 42);
        race("race42b", 42);
        race("race30", 30);
        settle();
        bus.showBest = 1'b1;
        convert_and_check("show_best30", 1'b1, m_best);

        bus.secondsPassed = 8'd10;
        bus.raceFinished  = 1'b1;
        bus.clearBest     = 1'b1;
        tick();
        m_best = 255;
        m_nr   = 1'b0;
        check("clear_wins.best", bus.bestTime, 8'hFF);
        check("clear_wins.new_record", bus.newRecord, 0);
        bus.clearBest    = 1'b0;
        bus.raceFinished = 1'b0;
        convert_and_check("clear_redisplay", 1'b1, 255);
        bus.showBest = 1'b0;

        for (int it = 0; it < 16; it++) begin
            settle();
            if ($urandom_range(0, 2) == 0) begin
                race($sformatf("rnd_race%0d", it), int'($urandom_range(0, 255)));
                settle();
            end
            prev_sel = bus.showBest;
            prev_src = prev_sel ? m_best : int'(bus.secondsPassed);
            sel = 1'($urandom_range(0, 1));
            v   = int'($urandom_range(0, 255));
            bus.showBest      = sel;
            bus.secondsPassed = 8'(v);
            src = sel ? m_best : v;
            if (sel != prev_sel || src != prev_src)
                convert_and_check($sformatf("rnd%0d", it), sel, src);
            else
                count_quiet($sformatf("rnd_same%0d", it), 15);
        end

        // Input change mid-conversion is held off until the next idle compare.
        bus.showBest = 1'b0;
        bus.secondsPassed = 8'd77;
        settle();
        bus.secondsPassed = 8'd9;
        repeat (3) tick();
        bus.secondsPassed = 8'd10;
        convert_and_check("midshift9", 1'b0, 9);
        repeat (8) tick();
        check("midshift10.valid_early", bus.bcdValid, 0);
        tick();
        check("midshift10.valid", bus.bcdValid, 1);
        check_hex("midshift10", 1'b0, 10);

        settle();
        bus.secondsPassed = 8'd200;
        repeat (4) tick();
        rst = 1'b1;
        bus.secondsPassed = 8'd0;
        tick();
        rst = 1'b0;
        m_best = 255;
        check_hex("abort", 1'b0, 0);
        check("abort.best", bus.bestTime, 8'hFF);
        check("abort.valid", bus.bcdValid, 0);
        count_quiet("abort_idle", 15);
        check("abort.hex0_kept", bus.hex0, 7'b1000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
